// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared segment encoder, constants and frame type for the FND register viewer
package fnd_pkg;

    localparam logic [7:0] SEG_DASH     = 8'hBF;
    localparam logic [7:0] SEG_BLANK    = 8'hFF;
    localparam int         DP_BIT       = 7;
    localparam int         FRAME_DATA_W = 64;
    localparam int         FRAME_IDX_W  = 8;

    // Sized for the widest supported source and index; narrower instances zero-extend.
    typedef struct packed {
        logic [FRAME_DATA_W-1:0] data;
        logic [FRAME_IDX_W-1:0]  idx;
        logic                    err;
        logic                    auto_mode;
    } disp_frame_t;

    function automatic logic [7:0] hex2seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_scan.sv
// rtl/fnd_scan.sv - digit scan timer: digit pointer, frame start strobe and active-low common drive
module fnd_scan
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    output logic [$clog2(NUM_DIGITS)-1:0] dig_o,
    output logic                          frame_start_o,
    output logic [NUM_DIGITS-1:0]         com_o,
    output logic                          run_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DIG_W = $clog2(NUM_DIGITS);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIG_W-1:0] dig_q;

    // run_q holds the counters at zero for one cycle after release so frame 0 starts cleanly.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            dig_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                if (cnt_q == CNT_W'(SCAN_DIV-1)) begin
                    cnt_q <= '0;
                    dig_q <= (dig_q == DIG_W'(NUM_DIGITS-1)) ? '0 : dig_q + DIG_W'(1);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign frame_start_o = run_q && (cnt_q == '0) && (dig_q == '0);
    assign dig_o         = dig_q;
    assign run_o         = run_q;

    always_comb begin
        com_o = '1;
        if (run_q) com_o[dig_q] = 1'b0;
    end

endmodule

// File: rtl/fnd_reg_viewer.sv
// rtl/fnd_reg_viewer.sv - selects one of NUM_SRC registers (manual one-hot or round-robin) and scans it onto the FND
module fnd_reg_viewer
    import fnd_pkg::*;
#(
    parameter int NUM_SRC    = 12,
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int AUTO_DIV   = 100000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           sel,
    input  logic                         auto_en,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic [7:0]                   fndFont,
    output logic [NUM_DIGITS-1:0]        fndCom,
    output logic [$clog2(NUM_SRC)-1:0]   active_idx,
    output logic                         sel_err
);

    localparam int DATA_DIG = DATA_W / 4;
    localparam int IDX_W    = $clog2(NUM_SRC);
    localparam int DWELL_W  = $clog2(AUTO_DIV);
    localparam int DIG_W    = $clog2(NUM_DIGITS);

    logic [IDX_W-1:0]      man_idx;
    logic                  man_ok;
    logic                  auto_q;
    logic                  auto_rise;
    logic [DWELL_W-1:0]    dwell_q;
    logic [IDX_W-1:0]      auto_idx_q;
    logic [IDX_W-1:0]      live_idx;
    disp_frame_t           live;
    disp_frame_t           snap_q;
    disp_frame_t           snap_d;
    logic [DIG_W-1:0]      dig;
    logic                  frame_start;
    logic [NUM_DIGITS-1:0] com;
    logic                  run;
    int                    dig_n;
    logic [3:0]            nib;
    logic [7:0]            seg_d;

    // An invalid selection decodes to index 0 so an auto-mode entry from it starts at source 0.
    always_comb begin
        man_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel[i]) man_idx = IDX_W'(i);
        end
        man_ok = ($countones(sel) == 1);
        if (!man_ok) man_idx = '0;
    end

    assign auto_rise = auto_en && !auto_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            auto_q     <= 1'b0;
            dwell_q    <= '0;
            auto_idx_q <= '0;
        end else begin
            auto_q <= auto_en;
            if (auto_rise) begin
                dwell_q    <= '0;
                auto_idx_q <= man_idx;
            end else if (auto_en) begin
                if (dwell_q == DWELL_W'(AUTO_DIV-1)) begin
                    dwell_q    <= '0;
                    auto_idx_q <= (auto_idx_q == IDX_W'(NUM_SRC-1)) ? '0 : auto_idx_q + IDX_W'(1);
                end else begin
                    dwell_q <= dwell_q + DWELL_W'(1);
                end
            end
        end
    end

    always_comb begin
        live_idx       = auto_en ? (auto_rise ? man_idx : auto_idx_q) : man_idx;
        live           = '0;
        live.data      = FRAME_DATA_W'(src_data[int'(live_idx)*DATA_W +: DATA_W]);
        live.idx       = FRAME_IDX_W'(live_idx);
        live.err       = !auto_en && !man_ok;
        live.auto_mode = auto_en;
    end

    fnd_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clk_i         (clk),
        .resetn_i      (reset),
        .dig_o         (dig),
        .frame_start_o (frame_start),
        .com_o         (com),
        .run_o         (run)
    );

    // Outputs read snap_d so the first digit of a frame already shows the freshly captured word.
    assign snap_d = frame_start ? live : snap_q;

    always_ff @(posedge clk) begin
        if (!reset) snap_q <= '0;
        else        snap_q <= snap_d;
    end

    always_comb begin
        dig_n = int'(dig);
        nib   = '0;
        if (dig_n < DATA_DIG) begin
            nib = snap_d.data[dig_n*4 +: 4];
        end else if (dig_n - DATA_DIG < FRAME_IDX_W/4) begin
            nib = snap_d.idx[(dig_n-DATA_DIG)*4 +: 4];
        end
        seg_d = snap_d.err ? SEG_DASH : hex2seg(nib);
        if (snap_d.auto_mode && dig_n == NUM_DIGITS-1) seg_d[DP_BIT] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset || !run) begin
            fndCom     <= '1;
            fndFont    <= SEG_BLANK;
            active_idx <= '0;
            sel_err    <= 1'b0;
        end else begin
            fndCom     <= com;
            fndFont    <= seg_d;
            active_idx <= snap_d.idx[IDX_W-1:0];
            sel_err    <= snap_d.err;
        end
    end

endmodule

// File: tb/tb_fnd_reg_viewer.sv
// tb/tb_fnd_reg_viewer.sv - randomized self-checking bench for fnd_reg_viewer against a frame-level model
module tb_fnd_reg_viewer;

    localparam int NUM_SRC    = 12;
    localparam int DATA_W     = 8;
    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 4;
    localparam int AUTO_DIV   = 64;
    localparam int FRAME      = NUM_DIGITS * SCAN_DIV;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_SRC-1:0]        sel;
    logic                      auto_en;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [7:0]                fndFont;
    logic [NUM_DIGITS-1:0]     fndCom;
    logic [3:0]                active_idx;
    logic                      sel_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    fnd_reg_viewer #(
        .NUM_SRC    (NUM_SRC),
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .AUTO_DIV   (AUTO_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .auto_en    (auto_en),
        .src_data   (src_data),
        .fndFont    (fndFont),
        .fndCom     (fndCom),
        .active_idx (active_idx),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: positions are counted from reset release, auto index from the rise time.
    bit         model_on = 0;
    int         tick = 0, cyc = 0, t_rise = 0, a_start = 0;
    bit         a_prev = 0;
    int         ones, midx, lidx, pos, d, nib;
    logic [7:0] f_data;
    int         f_idx;
    bit         f_err, f_auto;
    logic [3:0] e_com;
    logic [7:0] e_font;
    int         e_idx;
    bit         e_err;

    always @(posedge clk) begin
        tick++;
        if (!reset) begin
            model_on = 1;
            cyc = 0; a_prev = 0;
            f_data = '0; f_idx = 0; f_err = 0; f_auto = 0;
            e_com = 4'hF; e_font = 8'hFF; e_idx = 0; e_err = 0;
        end else begin
            ones = $countones(sel);
            midx = 0;
            for (int i = 0; i < NUM_SRC; i++) if (sel[i]) midx = i;
            if (ones != 1) midx = 0;
            if (auto_en && !a_prev) begin
                t_rise  = tick;
                a_start = midx;
            end
            a_prev = auto_en;
            if (auto_en) lidx = (a_start + ((tick == t_rise) ? 0 : (tick - t_rise - 1) / AUTO_DIV)) % NUM_SRC;
            else         lidx = midx;
            if (cyc == 0) begin
                e_com = 4'hF; e_font = 8'hFF; e_idx = 0; e_err = 0;
            end else begin
                pos = cyc - 1;
                if (pos % FRAME == 0) begin
                    f_auto = auto_en;
                    f_err  = !auto_en && (ones != 1);
                    f_idx  = lidx;
                    f_data = src_data[lidx*DATA_W +: DATA_W];
                end
                d     = (pos / SCAN_DIV) % NUM_DIGITS;
                e_com = ~(4'b0001 << d);
                nib   = (d < 2) ? int'((f_data >> (4*d)) & 8'h0F) : ((f_idx >> (4*(d-2))) & 15);
                e_font = f_err ? 8'hBF : hex_tab[nib];
                if (f_auto && d == NUM_DIGITS-1) e_font[7] = 1'b0;
                e_idx = f_idx;
                e_err = f_err;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("m_com", 32'(fndCom), 32'(e_com));
            check("m_font", 32'(fndFont), 32'(e_font));
            check("m_err", 32'(sel_err), 32'(e_err));
            if (!e_err) check("m_idx", 32'(active_idx), 32'(e_idx));
        end
    end

    logic [7:0] g [4];

    task automatic grab_frame();
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            for (int j = 0; j < NUM_DIGITS; j++) if (fndCom == ~(4'b0001 << j)) g[j] = fndFont;
        end
    endtask

    task automatic wait_idx(input int target, input int bound, input string tag);
        int n = 0;
        while (active_idx !== 4'(target) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(active_idx), 32'(target));
    endtask

    initial begin
        reset = 1'b0; sel = '0; auto_en = 1'b0; src_data = '0;
        repeat (3) @(negedge clk);
        check("rst_com", 32'(fndCom), 32'hF);
        check("rst_font", 32'(fndFont), 32'hFF);
        check("rst_idx", 32'(active_idx), 32'h0);
        check("rst_err", 32'(sel_err), 32'h0);

        reset = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1)  check("com_first", 32'(fndCom), 32'hF);
            if (k == 2)  check("com_d0", 32'(fndCom), 32'hE);
            if (k == 6)  check("com_d1", 32'(fndCom), 32'hD);
            if (k == 10) check("com_d2", 32'(fndCom), 32'hB);
            if (k == 14) check("com_d3", 32'(fndCom), 32'h7);
        end

        for (int s = 0; s < NUM_SRC; s++) src_data[s*DATA_W +: DATA_W] = 8'($urandom);
        src_data[5*DATA_W +: DATA_W] = 8'hA7;
        sel = 12'h020;
        repeat (2*FRAME) @(negedge clk);
        grab_frame();
        check("s5_d0", 32'(g[0]), 32'hF8);
        check("s5_d1", 32'(g[1]), 32'h88);
        check("s5_d2", 32'(g[2]), 32'h92);
        check("s5_d3", 32'(g[3]), 32'hC0);
        check("s5_idx", 32'(active_idx), 32'h5);
        check("s5_err", 32'(sel_err), 32'h0);

        sel = '0;
        repeat (2*FRAME) @(negedge clk);
        grab_frame();
        check("zero_dash0", 32'(g[0]), 32'hBF);
        check("zero_dash3", 32'(g[3]), 32'hBF);
        check("zero_err", 32'(sel_err), 32'h1);
        sel = 12'h00C;
        repeat (2*FRAME) @(negedge clk);
        grab_frame();
        check("multi_dash2", 32'(g[2]), 32'hBF);
        check("multi_err", 32'(sel_err), 32'h1);
        sel = 12'h020;
        repeat (FRAME+2) @(negedge clk);
        check("restore_err", 32'(sel_err), 32'h0);

        sel = 12'h400;
        auto_en = 1'b1;
        repeat (FRAME+2) @(negedge clk);
        check("auto_start", 32'(active_idx), 32'hA);
        sel = 12'h001;
        wait_idx(11, 4*AUTO_DIV, "auto_11");
        sel = 12'h0F0;
        wait_idx(0, 4*AUTO_DIV, "auto_0");
        wait_idx(1, 4*AUTO_DIV, "auto_1");
        wait_idx(7, 8*AUTO_DIV, "auto_7");
        reset = 1'b0;
        @(negedge clk);
        check("midrst_com", 32'(fndCom), 32'hF);
        check("midrst_font", 32'(fndFont), 32'hFF);
        check("midrst_idx", 32'(active_idx), 32'h0);
        check("midrst_err", 32'(sel_err), 32'h0);
        reset = 1'b1;

        for (int it = 0; it < 150; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                sel = '0;
                sel[$urandom_range(0, NUM_SRC-1)] = 1'b1;
            end else if (r < 8) begin
                sel = '0;
            end else begin
                sel = 12'($urandom);
            end
            for (int s = 0; s < NUM_SRC; s++) src_data[s*DATA_W +: DATA_W] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) auto_en = !auto_en;
            reset = ($urandom_range(0, 30) == 0) ? 1'b0 : 1'b1;
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
